// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit direction counter and table entry layout.
// Pure definitions; no logic, no latency, no flow control.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  // Tag field is sized for the widest supported PC; unused upper bits stay zero.
  localparam int TAG_MAX = 30;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
    ctr_t               ctr;
  } bp_entry_t;

  localparam bp_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating counter (set > inc > dec priority).
// Purely combinational; no flow control.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t cur,
  input  logic inc,
  input  logic dec,
  input  logic set,
  input  ctr_t set_val,
  output ctr_t nxt
);

  always_comb begin
    nxt = cur;
    if (set) begin
      nxt = set_val;
    end else if (inc && (cur != ST)) begin
      nxt = ctr_t'(cur + 2'd1);
    end else if (dec && (cur != SNT)) begin
      nxt = ctr_t'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit direction predictor; combinational lookup, updates visible next cycle.
// halt freezes predictions, redirects and all state; optional counters under BP_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  input  logic            halt,
  output logic            pred_taken,
  output logic [31:0]     pred_pc,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_taken,
  input  logic [31:0]     ex_target,
  input  logic            ex_pred_taken,
  input  logic [31:0]     ex_pred_pc,
  output logic            mispredict,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  if ((ENTRIES < 2) || ((1 << IDX_W) != ENTRIES) || (TAG_W < 1) || (TAG_W > TAG_MAX) || (PC_W > 32))
  begin : g_bad_cfg
    $error("branch_predictor: unsupported PC_W/ENTRIES combination");
  end

  bp_entry_t tbl_q [ENTRIES];

  // ---------------- fetch-side lookup ----------------
  logic [IDX_W-1:0]   if_idx;
  logic [TAG_MAX-1:0] if_tag;
  logic [31:0]        if_pc32;
  bp_entry_t          if_ent;
  logic               if_hit;

  always_comb begin
    if_idx              = if_pc[IDX_W+1:2];
    if_tag              = '0;
    if_tag[TAG_W-1:0]   = if_pc[PC_W-1:IDX_W+2];
    if_pc32             = 32'(if_pc);
    if_ent              = tbl_q[if_idx];
    if_hit              = if_ent.valid && (if_ent.tag == if_tag);
    pred_taken          = 1'b0;
    pred_pc             = if_pc32;
    if (!halt) begin
      pred_taken = if_hit && if_ent.ctr[1];
      pred_pc    = pred_taken ? if_ent.target : (if_pc32 + 32'd4);
    end
  end

  // ---------------- execute-side resolution ----------------
  logic [IDX_W-1:0]   ex_idx;
  logic [TAG_MAX-1:0] ex_tag;
  logic [31:0]        ex_pc32;
  bp_entry_t          ex_ent;
  logic               ex_hit;
  logic               ex_cf;
  logic               act;
  logic               upd_en;
  logic               wr_en;
  bp_entry_t          wr_ent;
  ctr_t               ctr_cur;
  ctr_t               ctr_set_val;
  ctr_t               ctr_nxt;
  logic               ctr_inc;
  logic               ctr_dec;
  logic               ctr_set;

  always_comb begin
    ex_idx            = ex_pc[IDX_W+1:2];
    ex_tag            = '0;
    ex_tag[TAG_W-1:0] = ex_pc[PC_W-1:IDX_W+2];
    ex_pc32           = 32'(ex_pc);
    ex_ent            = tbl_q[ex_idx];
    ex_hit            = ex_ent.valid && (ex_ent.tag == ex_tag);
    ex_cf             = ex_branch || ex_jump;
    act               = ex_jump || (ex_branch && ex_taken);
    mispredict        = !halt && ex_valid && ex_cf &&
                        ((act != ex_pred_taken) || (act && (ex_target != ex_pred_pc)));
    redirect_pc       = act ? ex_target : (ex_pc32 + 32'd4);
    upd_en            = ex_valid && ex_cf && !halt;
    // A miss only allocates when control actually transferred.
    wr_en             = upd_en && (ex_hit || act);
    ctr_cur           = ex_ent.ctr;
    ctr_inc           = ex_branch && ex_taken;
    ctr_dec           = ex_branch && !ex_taken;
    ctr_set           = ex_jump || !ex_hit;
    ctr_set_val       = ex_jump ? ST : WT;
  end

  sat_counter2 u_ctr (
    .cur     (ctr_cur),
    .inc     (ctr_inc),
    .dec     (ctr_dec),
    .set     (ctr_set),
    .set_val (ctr_set_val),
    .nxt     (ctr_nxt)
  );

  always_comb begin
    wr_ent        = ex_ent;
    wr_ent.valid  = 1'b1;
    wr_ent.tag    = ex_tag;
    wr_ent.ctr    = ctr_nxt;
    if (act) begin
      wr_ent.target = ex_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i] <= ENTRY_RESET;
      end
    end else if (wr_en) begin
      tbl_q[ex_idx] <= wr_ent;
    end
  end

  // ---------------- statistics ----------------
`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mp_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd_en && (br_cnt_q != 32'hFFFF_FFFF)) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (mispredict && (mp_cnt_q != 32'hFFFF_FFFF)) begin
        mp_cnt_q <= mp_cnt_q + 32'd1;
      end
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, counter hysteresis, aliasing, halt, reset, stats.
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [8:0]  if_pc;
  logic        halt;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid;
  logic [8:0]  ex_pc;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;
  int nb = 0;
  int nm = 0;

  branch_predictor #(.PC_W(9), .ENTRIES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .halt             (halt),
    .pred_taken       (pred_taken),
    .pred_pc          (pred_pc),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_branch        (ex_branch),
    .ex_jump          (ex_jump),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_pc       (ex_pred_pc),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_taken = 0;
    ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_pc = '0;
  endtask

  // Drives one resolution and tallies what the statistics counters should see.
  task automatic drive_ex(input logic br, input logic jp, input logic tk, input logic [8:0] pc,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc,
                          input logic exp_mp);
    ex_valid = 1; ex_branch = br; ex_jump = jp; ex_taken = tk; ex_pc = pc;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_pc = ppc;
    if (!halt && !reset && (br || jp)) begin
      nb++;
      if (exp_mp) nm++;
    end
  endtask

  task automatic test_reset();
    reset = 1; halt = 0; idle(); if_pc = 9'h040;
    tick();
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pt: got %0b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h44) begin errors++; $display("FAIL rst_ppc: got %h exp 00000044", pred_pc); end
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rst_mp_idle: got %0b exp 0", mispredict); end
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL rst_sb: got %0d exp 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL rst_sm: got %0d exp 0", stat_mispredicts); end
    drive_ex(1, 0, 1, 9'h040, 32'h80, 0, 32'h44, 1);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rst_mp_comb: got %0b exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL rst_redir: got %h exp 00000080", redirect_pc); end
    tick();
    idle(); reset = 0;
    tick();
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_no_upd: got %0b exp 0", pred_taken); end
    halt = 1; #1;
    checks++; if (pred_pc !== 32'h40) begin errors++; $display("FAIL halt_ppc: got %h exp 00000040", pred_pc); end
    halt = 0;
  endtask

  task automatic test_alloc();
    if_pc = 9'h040;
    drive_ex(1, 0, 1, 9'h040, 32'h80, 0, 32'h44, 1);
    #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mp: got %0b exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL alloc_redir: got %h exp 00000080", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_nobypass: got %0b exp 0", pred_taken); end
    tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pt: got %0b exp 1", pred_taken); end
    checks++; if (pred_pc !== 32'h80) begin errors++; $display("FAIL alloc_ppc: got %h exp 00000080", pred_pc); end
  endtask

  task automatic test_counter();
    if_pc = 9'h040;
    drive_ex(1, 0, 0, 9'h040, 32'h80, 1, 32'h80, 1); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL ctr_nt_mp: got %0b exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL ctr_nt_redir: got %h exp 00000044", redirect_pc); end
    tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_wnt_pt: got %0b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h44) begin errors++; $display("FAIL ctr_wnt_ppc: got %h exp 00000044", pred_pc); end
    drive_ex(1, 0, 0, 9'h040, 32'h80, 0, 32'h44, 0); #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL ctr_nt_ok: got %0b exp 0", mispredict); end
    tick();
    drive_ex(1, 0, 0, 9'h040, 32'h80, 0, 32'h44, 0); tick();
    drive_ex(1, 0, 1, 9'h040, 32'h80, 0, 32'h44, 1); tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_snt_sat: got %0b exp 0", pred_taken); end
    drive_ex(1, 0, 1, 9'h040, 32'h80, 0, 32'h44, 1); tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_wt_pt: got %0b exp 1", pred_taken); end
    drive_ex(1, 0, 1, 9'h040, 32'h80, 1, 32'h80, 0); #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL ctr_t_ok: got %0b exp 0", mispredict); end
    tick();
    drive_ex(1, 0, 1, 9'h040, 32'h80, 1, 32'h80, 0); tick();
    drive_ex(1, 0, 0, 9'h040, 32'h80, 1, 32'h80, 1); tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL ctr_st_sat: got %0b exp 1", pred_taken); end
    drive_ex(1, 0, 0, 9'h040, 32'h80, 1, 32'h80, 1); tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ctr_back_wnt: got %0b exp 0", pred_taken); end
  endtask

  task automatic test_alias();
    drive_ex(0, 1, 0, 9'h040, 32'h100, 1, 32'h100, 0); #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL jmp_ok_mp: got %0b exp 0", mispredict); end
    tick(); idle(); if_pc = 9'h040; #1;
    checks++; if (pred_pc !== 32'h100) begin errors++; $display("FAIL jmp_hit_ppc: got %h exp 00000100", pred_pc); end
    drive_ex(0, 1, 0, 9'h080, 32'h120, 0, 32'h84, 1); #1;
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL jmp_redir: got %h exp 00000120", redirect_pc); end
    tick(); idle(); if_pc = 9'h040; #1;
    checks++; if (pred_pc !== 32'h44) begin errors++; $display("FAIL alias_old_miss: got %h exp 00000044", pred_pc); end
    if_pc = 9'h080; #1;
    checks++; if (pred_pc !== 32'h120) begin errors++; $display("FAIL alias_new_hit: got %h exp 00000120", pred_pc); end
    drive_ex(1, 0, 0, 9'h080, 32'h120, 1, 32'h120, 1); tick(); idle(); #1;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jmp_alloc_st: got %0b exp 1", pred_taken); end
    drive_ex(1, 0, 0, 9'h040, 32'h300, 0, 32'h44, 0); tick(); idle(); #1;
    checks++; if (pred_pc !== 32'h120) begin errors++; $display("FAIL nt_no_alloc: got %h exp 00000120", pred_pc); end
    ex_valid = 1; ex_pc = 9'h080; ex_taken = 1; ex_target = 32'h200; #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL noncf_mp: got %0b exp 0", mispredict); end
    tick(); idle(); #1;
    checks++; if (pred_pc !== 32'h120) begin errors++; $display("FAIL noncf_state: got %h exp 00000120", pred_pc); end
  endtask

  task automatic test_target_halt();
    halt = 1; if_pc = 9'h080;
    drive_ex(1, 0, 1, 9'h040, 32'h80, 1, 32'h90, 0); #1;
    checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL halt_mp: got %0b exp 0", mispredict); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL halt_pt: got %0b exp 0", pred_taken); end
    checks++; if (pred_pc !== 32'h80) begin errors++; $display("FAIL halt_ppc2: got %h exp 00000080", pred_pc); end
    tick(); halt = 0; idle(); #1;
    checks++; if (pred_pc !== 32'h120) begin errors++; $display("FAIL halt_nochg: got %h exp 00000120", pred_pc); end
    drive_ex(1, 0, 1, 9'h040, 32'h80, 1, 32'h90, 1); #1;
    checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL tgt_mp: got %0b exp 1", mispredict); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL tgt_redir: got %h exp 00000080", redirect_pc); end
    tick(); idle(); if_pc = 9'h040; #1;
    checks++; if (pred_pc !== 32'h80) begin errors++; $display("FAIL tgt_alloc: got %h exp 00000080", pred_pc); end
    if_pc = 9'h080; #1;
    checks++; if (pred_pc !== 32'h84) begin errors++; $display("FAIL tgt_evict: got %h exp 00000084", pred_pc); end
    drive_ex(1, 0, 1, 9'h040, 32'h60, 1, 32'h80, 1); tick(); idle(); if_pc = 9'h040; #1;
    checks++; if (pred_pc !== 32'h60) begin errors++; $display("FAIL tgt_rewrite: got %h exp 00000060", pred_pc); end
  endtask

  task automatic test_wrap();
    if_pc = 9'h1FC; #1;
    checks++; if (pred_pc !== 32'h200) begin errors++; $display("FAIL wrap_ppc: got %h exp 00000200", pred_pc); end
    drive_ex(1, 0, 0, 9'h1FC, 32'h0, 1, 32'h0, 1); #1;
    checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL wrap_redir: got %h exp 00000200", redirect_pc); end
    tick(); idle();
  endtask

  task automatic test_stats();
`ifdef BP_STATS_EN
    checks++; if (stat_branches !== 32'(nb)) begin errors++; $display("FAIL stat_br: got %0d exp %0d", stat_branches, nb); end
    checks++; if (stat_mispredicts !== 32'(nm)) begin errors++; $display("FAIL stat_mp: got %0d exp %0d", stat_mispredicts, nm); end
`else
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL stat_br_off: got %0d exp 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL stat_mp_off: got %0d exp 0", stat_mispredicts); end
`endif
  endtask

  task automatic test_reset_midop();
    reset = 1;
    drive_ex(1, 0, 1, 9'h048, 32'h180, 0, 32'h4C, 1);
    if_pc = 9'h040; #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid_rst_pt: got %0b exp 0", pred_taken); end
    tick(); idle(); reset = 0; tick();
    if_pc = 9'h048; #1;
    checks++; if (pred_pc !== 32'h4C) begin errors++; $display("FAIL mid_rst_discard: got %h exp 0000004c", pred_pc); end
    if_pc = 9'h040; #1;
    checks++; if (pred_pc !== 32'h44) begin errors++; $display("FAIL mid_rst_miss: got %h exp 00000044", pred_pc); end
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL mid_rst_sb: got %0d exp 0", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd0) begin errors++; $display("FAIL mid_rst_sm: got %0d exp 0", stat_mispredicts); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_target_halt();
    test_wrap();
    test_stats();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning the PC width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning the table depth; it SHALL be a power of 2 and at least 2. Derived: IDX_W=log2(ENTRIES), TAG_W=PC_W-IDX_W-2.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port if_pc, input, PC_W: fetch-stage PC being looked up.
REQ-006 Port halt, input, 1: the pipeline is halted.
REQ-007 Port pred_taken, output, 1: predict taken for if_pc.
REQ-008 Port pred_pc, output, 32: predicted next fetch PC.
REQ-009 Port ex_valid, input, 1: a control-flow resolution is present this cycle.
REQ-010 Port ex_pc, input, PC_W: PC of the resolving instruction.
REQ-011 Port ex_branch / ex_jump, input, 1 each: conditional branch / unconditional jump (jal or jalr). They are mutually exclusive.
REQ-012 Port ex_taken, input, 1: actual branch outcome (ignored for jumps, which are always taken).
REQ-013 Port ex_target, input, 32: actual taken target (PC+Imm, or the ALU result for jalr).
REQ-014 Port ex_pred_taken, input, 1, and ex_pred_pc, input, 32: the prediction carried down the pipeline.
REQ-015 Port mispredict, output, 1: a redirect is required.
REQ-016 Port redirect_pc, output, 32: the corrected fetch PC.
REQ-017 Port stat_branches, output, 32: resolved-branch counter (see Configuration).
REQ-018 Port stat_mispredicts, output, 32: mispredict counter (see Configuration).

Function
REQ-019 Each table entry SHALL hold valid, tag[TAG_W], target[32], and a 2-bit counter (SNT=0, WNT=1, WT=2, ST=3).
REQ-020 Indexing: idx=pc[IDX_W+1:2]; tag=pc[PC_W-1:IDX_W+2]. PCs SHALL be zero-extended to 32 bits for all arithmetic, which wraps modulo 2^32.
REQ-021 Lookup SHALL be combinational from registered state: hit = valid && tag match; pred_taken = hit && counter[1]; pred_pc = pred_taken ? target : if_pc+4.
REQ-022 While halt=1: pred_taken SHALL be 0, pred_pc SHALL be if_pc, and mispredict SHALL be 0.
REQ-023 While halt=1, table and stat updates SHALL be suppressed.
REQ-024 Actual taken: act = ex_jump || (ex_branch && ex_taken).
REQ-025 mispredict SHALL be combinational and equal ex_valid && (ex_branch||ex_jump) && (act!=ex_pred_taken || (act && ex_target!=ex_pred_pc)).
REQ-026 redirect_pc = act ? ex_target : ex_pc+4. When mispredict=0, redirect_pc is don't-care.
REQ-027 Update on a branch hit: the counter SHALL saturate-increment if taken and saturate-decrement if not; the target SHALL be rewritten on taken. ST+taken stays ST; SNT+not-taken stays SNT.
REQ-028 Update on a jump hit: the counter SHALL be set to ST and the target rewritten.
REQ-029 Update on a miss: a taken branch SHALL allocate the entry (valid=1, tag, target, counter WT); a jump SHALL allocate with counter ST; a not-taken branch SHALL NOT allocate.
REQ-030 Allocation SHALL replace the indexed entry unconditionally (direct-mapped).
REQ-031 Update-to-lookup latency SHALL be 1 cycle. A same-cycle lookup of the entry being updated returns the old contents (no bypass).
REQ-032 ex_valid with neither ex_branch nor ex_jump SHALL change no state.

Reset
REQ-033 Asserting reset SHALL clear all valid bits and set all counters to WNT; targets and tags need no reset.
REQ-034 During reset, pred_taken=0, pred_pc=if_pc+4, and mispredict follows REQ-025 combinationally.
REQ-035 When reset asserts mid-operation, a pending update is discarded and the first post-reset lookup misses.

Configuration
REQ-036 Macro BP_STATS_EN, when defined, SHALL include two 32-bit counters. stat_branches counts resolved branches and jumps; stat_mispredicts counts cycles with mispredict=1. Both saturate at 0xFFFFFFFF, reset to 0, and do not count while halt=1.
REQ-037 Without BP_STATS_EN, stat_branches and stat_mispredicts SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-038 Package bp_pkg SHALL hold the counter enum (SNT/WNT/WT/ST), the entry struct typedef, and the reset counter constant WNT.
REQ-039 Sub-module sat_counter2 (2-bit saturating next-state logic: inc/dec/set) SHALL be instantiated by branch_predictor; the table SHALL be flop-based.

Verification
REQ-040 Reset, then lookup any PC, e.g. if_pc=0x40 -> pred_taken=0, pred_pc=0x44.
REQ-041 Resolve taken branch ex_pc=0x40, target 0x80, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x80; next cycle lookup 0x40 -> pred_taken=1, pred_pc=0x80.
REQ-042 Two not-taken resolves at 0x40 (WT->WNT->SNT) -> lookup pred_taken=0. A third not-taken stays SNT; then two taken are needed before pred_taken=1.
REQ-043 ENTRIES=16: jump at 0x40 then jump at 0x40+64=0x80 (same idx, different tag) -> lookup 0x40 misses, lookup 0x80 hits with ST.
REQ-044 Taken branch with correct direction but ex_pred_pc=0x90 vs ex_target=0x80 -> mispredict=1, redirect_pc=0x80. halt=1 with the same inputs -> mispredict=0, no state change.
REQ-045 With BP_STATS_EN: 5 resolves, 2 mispredicts -> stat_branches=5, stat_mispredicts=2; then reset -> both 0.
